// File: rtl/gtp_rx_link_mon.sv
// rtl/gtp_rx_link_mon.sv - GTP lane rx link monitor: raw comma framing, link hysteresis, error counts
// Optional elastic-buffer error counting is built only when GTP_RXMON_BUFERR_EN is defined.
module gtp_rx_link_mon #(
  parameter int         FRAME_LEN    = 16,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 3,
  parameter logic [9:0] COMMA_NEG    = 10'h17C,
  parameter logic [9:0] COMMA_POS    = 10'h283
) (
  input  logic        rx_clk,
  input  logic        rx_reset_n_i,
  input  logic [9:0]  rxdata_i,
  input  logic [6:0]  rxstatus_i,
  input  logic        clr_i,
  output logic [9:0]  data_o,
  output logic        frame_o,
  output logic        link_up_o,
  output logic [1:0]  state_o,
  output logic [15:0] comma_err_o,
  output logic [15:0] buferr_o
);
  localparam int            PW         = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [3:0]    LOCK_N     = 4'(LOCK_COUNT);
  localparam logic [3:0]    UNLOCK_N   = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state, state_nx;
  logic [9:0]    s1_data;
  logic          s1_lost_sync, s1_aligned;
  logic [PW-1:0] phase, phase_nx;
  logic [3:0]    good, good_nx, miss, miss_nx;
  logic          is_comma, status_bad, buf_rise, err_inc, frame_nx;

  always_ff @(posedge rx_clk or negedge rx_reset_n_i) begin
    if (!rx_reset_n_i) begin
      s1_data      <= '0;
      s1_lost_sync <= 1'b0;
      s1_aligned   <= 1'b0;
    end else begin
      s1_data      <= rxdata_i;
      s1_lost_sync <= rxstatus_i[4];
      s1_aligned   <= rxstatus_i[3];
    end
  end

  assign is_comma   = (s1_data == COMMA_NEG) || (s1_data == COMMA_POS);
  assign status_bad = s1_lost_sync | ~s1_aligned;

`ifdef GTP_RXMON_BUFERR_EN
  logic s1_buf_err, buf_prev;
  logic unused_status;
  assign unused_status = ^{rxstatus_i[6:5], rxstatus_i[1:0]};
  assign buf_rise      = s1_buf_err & ~buf_prev;

  always_ff @(posedge rx_clk or negedge rx_reset_n_i) begin
    if (!rx_reset_n_i) begin
      s1_buf_err <= 1'b0;
      buf_prev   <= 1'b0;
      buferr_o   <= '0;
    end else begin
      s1_buf_err <= rxstatus_i[2];
      buf_prev   <= s1_buf_err;
      if (clr_i)
        buferr_o <= '0;
      else if (buf_rise && buferr_o != 16'hFFFF)
        buferr_o <= buferr_o + 16'd1;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^{rxstatus_i[6:5], rxstatus_i[2:0]};
  assign buf_rise      = 1'b0;
  assign buferr_o      = '0;
`endif

  always_comb begin
    state_nx = state;
    phase_nx = (phase == PHASE_LAST) ? '0 : phase + PHASE_ONE;
    good_nx  = good;
    miss_nx  = miss;
    err_inc  = 1'b0;
    frame_nx = 1'b0;
    case (state)
      HUNT: begin
        // Accepted comma defines phase 0, so the next one is due FRAME_LEN cycles later
        if (is_comma) begin
          phase_nx = PHASE_ONE;
          good_nx  = 4'd1;
          miss_nx  = 4'd0;
          state_nx = (LOCK_N == 4'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (phase == '0) begin
          if (is_comma) begin
            good_nx = good + 4'd1;
            if (good_nx >= LOCK_N) begin
              state_nx = LOCKED;
              miss_nx  = 4'd0;
            end
          end else begin
            state_nx = HUNT;
            good_nx  = 4'd0;
          end
        end else if (is_comma) begin
          state_nx = HUNT;
          good_nx  = 4'd0;
        end
      end
      LOCKED: begin
        // Lane status loss and buffer faults override all comma rules
        if (status_bad || buf_rise) begin
          state_nx = HUNT;
          good_nx  = 4'd0;
          err_inc  = status_bad;
        end else if (phase == '0) begin
          if (is_comma) begin
            miss_nx  = 4'd0;
            frame_nx = 1'b1;
          end else begin
            miss_nx = miss + 4'd1;
            err_inc = 1'b1;
            if (miss_nx >= UNLOCK_N) begin
              state_nx = HUNT;
              good_nx  = 4'd0;
            end
          end
        end else if (is_comma) begin
          err_inc = 1'b1;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n_i) begin
    if (!rx_reset_n_i) begin
      state       <= HUNT;
      phase       <= '0;
      good        <= '0;
      miss        <= '0;
      comma_err_o <= '0;
      link_up_o   <= 1'b0;
      state_o     <= 2'd0;
      data_o      <= '0;
      frame_o     <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      good      <= good_nx;
      miss      <= miss_nx;
      link_up_o <= (state == LOCKED);
      state_o   <= state;
      data_o    <= s1_data;
      frame_o   <= frame_nx;
      if (clr_i)
        comma_err_o <= '0;
      else if (err_inc && comma_err_o != 16'hFFFF)
        comma_err_o <= comma_err_o + 16'd1;
    end
  end

endmodule
